// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM state encoding and UART register map.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWrReq  = 3'd1,
        StWrResp = 3'd2,
        StRdReq  = 3'd3,
        StRdData = 3'd4,
        StDone   = 3'd5
    } state_e;

    // Word-index register offsets of the companion UART slave.
    localparam logic [1:0] UART_REG_RXDATA = 2'b00;
    localparam logic [1:0] UART_REG_TXDATA = 2'b01;
    localparam logic [1:0] UART_REG_STATUS = 2'b10;
    localparam logic [1:0] UART_REG_CTRL   = 2'b11;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator: turns one command/response handshake into
// one AXI4-Lite write or read transaction, with every AXI output driven from a register.
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter logic [2:0]  AXI_PROT = 3'b000
) (
    input  logic                  aclk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ADDR_W-1:0]     awaddr_out,
    output logic [2:0]            awprot_out,
    output logic                  awvalid_out,
    input  logic                  awready_in,
    output logic [DATA_W-1:0]     wdata_out,
    output logic [DATA_W/8-1:0]   wstrb_out,
    output logic                  wvalid_out,
    input  logic                  wready_in,
    input  logic [1:0]            bresp_in,
    input  logic                  bvalid_in,
    output logic                  bready_out,
    output logic [ADDR_W-1:0]     araddr_out,
    output logic [2:0]            arprot_out,
    output logic                  arvalid_out,
    input  logic                  arready_in,
    input  logic [DATA_W-1:0]     rdata_in,
    input  logic [1:0]            rresp_in,
    input  logic                  rvalid_in,
    output logic                  rready_out
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_e              state_q, state_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                arvalid_q, arvalid_d;
    logic                bready_q, bready_d;
    logic                rready_q, rready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_resp_q, rsp_resp_d;

    logic aw_hs, w_hs;

    assign aw_hs = awvalid_q & awready_in;
    assign w_hs  = wvalid_q & wready_in;

    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        state_d   = StWrReq;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = StRdReq;
                        arvalid_d = 1'b1;
                    end
                end
            end
            StWrReq: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // A handshake landing this cycle counts toward completion.
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    state_d  = StWrResp;
                    bready_d = 1'b1;
                end
            end
            StWrResp: begin
                if (bvalid_in) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = bresp_in;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StRdReq: begin
                if (arready_in) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdData;
                end
            end
            StRdData: begin
                if (rvalid_in) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = rdata_in;
                    rsp_resp_d  = rresp_in;
                    rsp_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign cmd_ready   = (state_q == StIdle);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign awaddr_out  = addr_q;
    assign awprot_out  = AXI_PROT;
    assign awvalid_out = awvalid_q;
    assign wdata_out   = wdata_q;
    assign wstrb_out   = wstrb_q;
    assign wvalid_out  = wvalid_q;
    assign bready_out  = bready_q;
    assign araddr_out  = addr_q;
    assign arprot_out  = AXI_PROT;
    assign arvalid_out = arvalid_q;
    assign rready_out  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: configurable-latency slave, protocol monitor and a
// transaction-level latency/data model driving directed and randomized commands.
module tb_axi4_lite_master;
    import axi4_lite_pkg::*;

    logic        aclk = 1'b0;
    logic        rst  = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr  = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr_out, araddr_out, wdata_out;
    logic [2:0]  awprot_out, arprot_out;
    logic [3:0]  wstrb_out;
    logic        awvalid_out, wvalid_out, arvalid_out, bready_out, rready_out;
    logic        awready_in, wready_in, arready_in, bvalid_in, rvalid_in;
    logic [1:0]  bresp_in, rresp_in;
    logic [31:0] rdata_in;

    axi4_lite_master dut (
        .aclk(aclk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr_out(awaddr_out), .awprot_out(awprot_out), .awvalid_out(awvalid_out),
        .awready_in(awready_in),
        .wdata_out(wdata_out), .wstrb_out(wstrb_out), .wvalid_out(wvalid_out),
        .wready_in(wready_in),
        .bresp_in(bresp_in), .bvalid_in(bvalid_in), .bready_out(bready_out),
        .araddr_out(araddr_out), .arprot_out(arprot_out), .arvalid_out(arvalid_out),
        .arready_in(arready_in),
        .rdata_in(rdata_in), .rresp_in(rresp_in), .rvalid_in(rvalid_in),
        .rready_out(rready_out)
    );

    always #5 aclk = ~aclk;

    // Slave configuration, set by the stimulus while the master is idle.
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  s_bresp = RESP_OKAY, s_rresp = RESP_OKAY;
    logic [31:0] s_rdata = '0;

    int   aw_wait, w_wait, ar_wait, b_cnt, r_cnt;
    logic aw_got, w_got, b_busy, r_busy;

    assign awready_in = awvalid_out && (aw_wait >= aw_dly);
    assign wready_in  = wvalid_out && (w_wait >= w_dly);
    assign arready_in = arvalid_out && (ar_wait >= ar_dly);
    assign bvalid_in  = b_busy && (b_cnt >= b_dly);
    assign rvalid_in  = r_busy && (r_cnt >= r_dly);
    assign bresp_in   = s_bresp;
    assign rresp_in   = s_rresp;
    assign rdata_in   = s_rdata;

    always @(posedge aclk or posedge rst) begin
        if (rst) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_busy <= 1'b0; r_busy <= 1'b0;
        end else begin
            aw_wait <= (awvalid_out && !awready_in) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid_out && !wready_in) ? w_wait + 1 : 0;
            ar_wait <= (arvalid_out && !arready_in) ? ar_wait + 1 : 0;
            if (awvalid_out && awready_in) aw_got <= 1'b1;
            if (wvalid_out && wready_in) w_got <= 1'b1;
            if (!b_busy && (aw_got || (awvalid_out && awready_in))
                        && (w_got || (wvalid_out && wready_in))) begin
                b_busy <= 1'b1;
                b_cnt  <= 0;
            end else if (b_busy && !bvalid_in) begin
                b_cnt <= b_cnt + 1;
            end
            if (bvalid_in && bready_out) begin
                b_busy <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (arvalid_out && arready_in) begin
                r_busy <= 1'b1;
                r_cnt  <= 0;
            end else if (r_busy && !rvalid_in) begin
                r_cnt <= r_cnt + 1;
            end
            if (rvalid_in && rready_out) r_busy <= 1'b0;
        end
    end

    // Monitor: handshake timestamps, captured payloads, protocol violations.
    int          cyc = 0, n_acc = 0, n_rsp = 0, acc_cyc = 0, rsp_cyc = 0, n_rready = 0, viol = 0;
    int          aw_hs_cyc = 0, w_hs_cyc = 0, ar_hs_cyc = 0, b_hs_cyc = 0, r_hs_cyc = 0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [3:0]  cap_wstrb = '0;
    logic [2:0]  cap_awprot = '0, cap_arprot = '0;
    logic        busy = 1'b0;
    logic        p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
    logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
    logic [3:0]  p_wstrb = '0;

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (rst) begin
            busy <= 1'b0; p_awv <= 1'b0; p_wv <= 1'b0; p_arv <= 1'b0;
        end else begin
            if (awvalid_out && awready_in) begin
                aw_hs_cyc <= cyc; cap_awaddr <= awaddr_out; cap_awprot <= awprot_out;
            end
            if (wvalid_out && wready_in) begin
                w_hs_cyc <= cyc; cap_wdata <= wdata_out; cap_wstrb <= wstrb_out;
            end
            if (arvalid_out && arready_in) begin
                ar_hs_cyc <= cyc; cap_araddr <= araddr_out; cap_arprot <= arprot_out;
            end
            if (bvalid_in && bready_out) b_hs_cyc <= cyc;
            if (rvalid_in && rready_out) r_hs_cyc <= cyc;
            if (rready_out) n_rready <= n_rready + 1;
            if ((bready_out && !(aw_got && w_got))
                || (p_awv && !p_awr && (!awvalid_out || awaddr_out != p_awaddr))
                || (p_wv && !p_wr && (!wvalid_out || wdata_out != p_wdata
                                      || wstrb_out != p_wstrb))
                || (p_arv && !p_arr && (!arvalid_out || araddr_out != p_araddr))
                || (busy && cmd_ready) || (rsp_valid && !busy))
                viol <= viol + 1;
            p_awv <= awvalid_out; p_awr <= awready_in; p_awaddr <= awaddr_out;
            p_wv  <= wvalid_out;  p_wr  <= wready_in;  p_wdata  <= wdata_out;
            p_wstrb <= wstrb_out;
            p_arv <= arvalid_out; p_arr <= arready_in; p_araddr <= araddr_out;
            if (cmd_valid && cmd_ready) begin
                n_acc <= n_acc + 1; acc_cyc <= cyc; busy <= 1'b1;
            end
            if (rsp_valid) begin
                n_rsp <= n_rsp + 1; rsp_cyc <= cyc; busy <= 1'b0;
            end
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic start_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_acc(output int c0);
        int n0 = n_acc;
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge aclk);
            if (n_acc != n0) ok = 1'b1;
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        c0 = acc_cyc;
    endtask

    // Waits for the response and checks it against the transaction-level model.
    task automatic expect_txn(input string tag, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] strb,
                              input logic [1:0] resp, input logic [31:0] rdata,
                              input int c0, input int rr0);
        int  n0 = n_rsp;
        bit  ok = 1'b0;
        int  last_req, lat;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge aclk);
            if (n_rsp != n0) ok = 1'b1;
        end
        if (!ok) begin
            check({tag, "_rsp_timeout"}, 64'd0, 64'd1);
            return;
        end
        if (wr) begin
            last_req = (aw_dly > w_dly) ? 1 + aw_dly : 1 + w_dly;
            lat = last_req + 1 + b_dly + 1;
            check({tag, "_aw_cyc"}, aw_hs_cyc - c0, 1 + aw_dly);
            check({tag, "_w_cyc"}, w_hs_cyc - c0, 1 + w_dly);
            check({tag, "_b_cyc"}, b_hs_cyc - c0, last_req + 1 + b_dly);
            check({tag, "_awaddr"}, cap_awaddr, addr);
            check({tag, "_wdata"}, cap_wdata, data);
            check({tag, "_wstrb"}, cap_wstrb, strb);
            check({tag, "_awprot"}, cap_awprot, 3'b000);
        end else begin
            lat = 1 + ar_dly + 1 + r_dly + 1;
            check({tag, "_ar_cyc"}, ar_hs_cyc - c0, 1 + ar_dly);
            check({tag, "_r_cyc"}, r_hs_cyc - c0, 1 + ar_dly + 1 + r_dly);
            check({tag, "_araddr"}, cap_araddr, addr);
            check({tag, "_arprot"}, cap_arprot, 3'b000);
            check({tag, "_rready_cycles"}, n_rready - rr0, r_dly + 1);
        end
        check({tag, "_latency"}, rsp_cyc - c0, lat);
        check({tag, "_rdata"}, rsp_rdata, wr ? 32'h0 : rdata);
        check({tag, "_resp"}, rsp_resp, resp);
        check({tag, "_single_pulse"}, rsp_valid, 1'b0);
        check({tag, "_ready_after"}, cmd_ready, 1'b1);
    endtask

    task automatic run(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb, input logic [1:0] resp,
                       input logic [31:0] rdata);
        int c0, rr0;
        s_bresp = resp; s_rresp = resp; s_rdata = rdata;
        rr0 = n_rready;
        start_cmd(wr, addr, data, strb);
        wait_acc(c0);
        cmd_valid = 1'b0;
        check({tag, "_busy_ready"}, cmd_ready, 1'b0);
        expect_txn(tag, wr, addr, data, strb, resp, rdata, c0, rr0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, rr0, nr0;
        logic [31:0] ra, rd;
        logic        rw;

        #1;
        check("rst_awvalid", awvalid_out, 1'b0);
        check("rst_wvalid", wvalid_out, 1'b0);
        check("rst_arvalid", arvalid_out, 1'b0);
        check("rst_bready", bready_out, 1'b0);
        check("rst_rready", rready_out, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_resp", rsp_resp, 2'b00);
        check("rst_addr", awaddr_out, 32'h0);
        repeat (2) @(negedge aclk);
        rst = 1'b0;
        @(negedge aclk);
        check("cmd_ready_out_of_rst", cmd_ready, 1'b1);

        // Zero-wait write and read.
        run("wr0", 1'b1, {30'd0, UART_REG_RXDATA}, 32'h0000_00A5, 4'hF, RESP_OKAY, 32'h1234_5678);
        run("rd0", 1'b0, {28'd0, UART_REG_STATUS, 2'b00}, 32'h0, 4'h0, RESP_EXOKAY, 32'h0BAD_CAFE);

        // Read with slow R channel.
        r_dly = 3;
        run("rd_slow", 1'b0, 32'h0000_0004, 32'h0, 4'h0, RESP_OKAY, 32'hDEAD_BEEF);
        r_dly = 0;

        // Skewed write: AW ready late, W ready immediately.
        aw_dly = 3;
        run("wr_skew", 1'b1, 32'h0000_0008, 32'h5A5A_0001, 4'h3, RESP_OKAY, 32'h0);
        aw_dly = 0; w_dly = 2; b_dly = 1;
        run("wr_skew_w", 1'b1, 32'h0000_000C, 32'hCAFE_F00D, 4'h8, RESP_OKAY, 32'h0);
        w_dly = 0; b_dly = 0;

        // Error passthrough, then an immediate follow-up command.
        run("wr_slverr", 1'b1, {28'd0, UART_REG_CTRL, 2'b00}, 32'h1, 4'h1, RESP_SLVERR, 32'h0);
        run("rd_decerr", 1'b0, 32'hFFFF_FFF0, 32'h0, 4'h0, RESP_DECERR, 32'h7777_0000);

        // Back-to-back: cmd_valid stays high across two commands.
        s_bresp = RESP_OKAY; s_rresp = RESP_OKAY; s_rdata = 32'h0102_0304;
        rr0 = n_rready;
        start_cmd(1'b1, {28'd0, UART_REG_TXDATA, 2'b00}, 32'h0000_0041, 4'h1);
        wait_acc(c0);
        start_cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        expect_txn("b2b_a", 1'b1, {28'd0, UART_REG_TXDATA, 2'b00}, 32'h0000_0041, 4'h1,
                   RESP_OKAY, 32'h0, c0, rr0);
        rr0 = n_rready;
        wait_acc(c1);
        cmd_valid = 1'b0;
        check("b2b_accept_cycle", c1 - rsp_cyc, 1);
        expect_txn("b2b_b", 1'b0, 32'h0000_0010, 32'h0, 4'h0, RESP_OKAY, 32'h0102_0304, c1, rr0);

        // Randomized transactions.
        for (int i = 0; i < 16; i++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly  = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            r_dly  = $urandom_range(0, 3);
            rw = 1'($urandom_range(0, 1));
            ra = $urandom; rd = $urandom;
            run($sformatf("rnd%0d", i), rw, ra, $urandom, 4'($urandom_range(0, 15)),
                2'($urandom_range(0, 3)), rd);
        end
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 10;

        // Reset while waiting for read data.
        start_cmd(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        wait_acc(c0);
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !rready_out; i++) @(negedge aclk);
        check("pre_rst_rready", rready_out, 1'b1);
        nr0 = n_rsp;
        rst = 1'b1;
        #1;
        check("mid_rst_rready", rready_out, 1'b0);
        check("mid_rst_arvalid", arvalid_out, 1'b0);
        check("mid_rst_awvalid", awvalid_out, 1'b0);
        check("mid_rst_wvalid", wvalid_out, 1'b0);
        check("mid_rst_bready", bready_out, 1'b0);
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        repeat (2) @(negedge aclk);
        rst = 1'b0;
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1'b1);
        repeat (12) @(negedge aclk);
        check("post_rst_no_rsp", n_rsp - nr0, 0);
        r_dly = 0;
        run("post_rst_wr", 1'b1, 32'h0000_0024, 32'hA5A5_5A5A, 4'hF, RESP_OKAY, 32'h0);

        check("protocol_violations", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
